// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing helpers for the sequential multiplier
// No ports: provides the FSM state encoding and the iteration-counter width helper.
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 32;

  // The counter must be able to hold DATA_WIDTH itself, not just DATA_WIDTH-1.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// rtl/seq_multiplier_if.sv - start/busy/done multiply request bundle
// Ports (via modports):
//   master drives A, B, sign, start, flush; observes busy, done, C
//   slave  observes A, B, sign, start, flush; drives busy, done, C
interface seq_multiplier_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0]   A;
  logic [DATA_WIDTH-1:0]   B;
  logic                    sign;
  logic                    start;
  logic                    flush;
  logic                    busy;
  logic                    done;
  logic [2*DATA_WIDTH-1:0] C;

  modport master (
    output A, B, sign, start, flush,
    input  busy, done, C
  );

  modport slave (
    input  A, B, sign, start, flush,
    output busy, done, C
  );

endinterface

// File: rtl/mult_sign_fix.sv
// rtl/mult_sign_fix.sv - conditional two's-complement negate
// Ports:
//   value_i  in  WIDTH  operand
//   negate_i in  1      1 = output the two's-complement negation of value_i
//   value_o  out WIDTH  value_i or -value_i (modulo 2^WIDTH)
// Used for operand magnitude extraction (negate when signed and MSB set) and for
// applying the result sign to the accumulated product.
module mult_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             negate_i,
  output logic [WIDTH-1:0] value_o
);

  // Magnitude of the most negative value wraps to itself, which read as unsigned
  // is exactly 2^(WIDTH-1) - the correct magnitude.
  assign value_o = negate_i ? (~value_i + WIDTH'(1)) : value_i;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier with start/busy/done handshake
// Ports:
//   clk    in  1  rising-edge clock
//   rst_n  in  1  asynchronous active-low reset
//   bus    slave modport of seq_multiplier_if:
//            A, B (DATA_WIDTH) operands sampled at an accepted start
//            sign  1 = signed operands, 0 = unsigned
//            start request, accepted only in IDLE when flush=0
//            flush abort; beats start and completion
//            busy  high in CALC and DONE
//            done  one-cycle completion pulse
//            C     2*DATA_WIDTH product {HI,LO}, held until the next completion
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_multiplier_if.slave bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = cnt_width(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [2*W-1:0]   acc_q,    acc_d;
  logic [2*W-1:0]   mcand_q,  mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic             neg_q,    neg_d;
  logic [2*W-1:0]   c_q,      c_d;

  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic [2*W-1:0]   acc_signed;
  logic             a_neg;
  logic             b_neg;

  assign a_neg = bus.sign & bus.A[W-1];
  assign b_neg = bus.sign & bus.B[W-1];

  mult_sign_fix #(.WIDTH(W)) u_mag_a (
    .value_i  (bus.A),
    .negate_i (a_neg),
    .value_o  (mag_a)
  );

  mult_sign_fix #(.WIDTH(W)) u_mag_b (
    .value_i  (bus.B),
    .negate_i (b_neg),
    .value_o  (mag_b)
  );

  // Negates straight off the accumulator register; the final CALC cycle is spent
  // on this so the wide negate never sits behind the adder in one cycle.
  mult_sign_fix #(.WIDTH(2*W)) u_fix_c (
    .value_i  (acc_q),
    .negate_i (neg_q),
    .value_o  (acc_signed)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    c_d      = c_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          mcand_d  = {{W{1'b0}}, mag_a};
          mplier_d = mag_b;
          neg_d    = bus.sign & (bus.A[W-1] ^ bus.B[W-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = S_CALC;
        end
      end

      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
        end else if (count_q == LAST_CNT) begin
          // All W partial products are in; publish the signed result.
          c_d     = acc_signed;
          state_d = S_DONE;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          count_d  = count_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      c_q      <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      c_q      <= c_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  // A flush in the DONE cycle must cancel the pulse in that same cycle.
  assign bus.done = (state_q == S_DONE) && !bus.flush;
  assign bus.C    = c_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier
module tb_seq_multiplier;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic clk = 1'b0;
  logic rst_n;

  seq_multiplier_if #(.DATA_WIDTH(W)) bus ();

  seq_multiplier #(.DATA_WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: full-width product from plain arithmetic on 64-bit integers.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x;
    longint y;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(x * y);
  endfunction

  // Presents a request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.sign  = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Waits for done, scrambling operands meanwhile; lat counts negedges after the accepting edge.
  task automatic wait_done(output bit got, output int lat, output bit busy_ok);
    got     = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      bus.A    = $urandom;
      bus.B    = $urandom;
      bus.sign = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input logic [63:0] exp);
    bit got;
    int lat;
    bit busy_ok;
    issue(a, b, s);
    wait_done(got, lat, busy_ok);
    check({name, " done_seen"}, 64'(got), 64'(1));
    check({name, " C"}, bus.C, exp);
    check({name, " latency"}, 64'(lat), 64'(LATENCY));
    check({name, " busy_held"}, 64'(busy_ok), 64'(1));
  endtask

  initial begin
    bit          got;
    int          lat;
    bit          busy_ok;
    bit          saw_done;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
    vecs[1] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
    vecs[2] = '{32'hFFFFFFFD, 32'h00000007, 1'b0, 64'h00000006_FFFFFFEB};
    vecs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
    vecs[4] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000};
    vecs[5] = '{32'h00000000, 32'h00012345, 1'b1, 64'h0};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h1};
    vecs[7] = '{32'h00000004, 32'h00000004, 1'b0, 64'd16};

    bus.A     = '0;
    bus.B     = '0;
    bus.sign  = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    rst_n     = 1'b0;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'(0));
    check("reset done", 64'(bus.done), 64'(0));
    check("reset C", bus.C, 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);
    end

    // Start during busy is ignored; start in the DONE cycle is ignored but accepted in IDLE.
    issue(32'd6, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    bus.A = 32'd5; bus.B = 32'd5; bus.sign = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(got, lat, busy_ok);
    check("busy_start done_seen", 64'(got), 64'(1));
    check("busy_start C", bus.C, 64'd42);
    bus.A = 32'd5; bus.B = 32'd5; bus.sign = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    check("idle after done busy", 64'(bus.busy), 64'(0));
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b accept busy", 64'(bus.busy), 64'(1));
    wait_done(got, lat, busy_ok);
    check("b2b C", bus.C, 64'd25);
    check("b2b latency", 64'(lat), 64'(LATENCY));

    // Flush in CALC: no done, C retains the prior product.
    run_and_check("pre_flush", 32'h1234, 32'd1, 1'b0, 64'h1234);
    issue(32'd2, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush_calc done", 64'(bus.done), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_calc busy", 64'(bus.busy), 64'(0));
    check("flush_calc C", bus.C, 64'h1234);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("flush_calc quiet", 64'(saw_done), 64'(0));
    check("flush_calc C held", bus.C, 64'h1234);

    // Flush in the DONE cycle cancels the pulse.
    issue(32'd9, 32'd9, 1'b0);
    wait_done(got, lat, busy_ok);
    check("flush_done reached", 64'(got), 64'(1));
    bus.flush = 1'b1;
    #1;
    check("flush_done pulse", 64'(bus.done), 64'(0));
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_done busy", 64'(bus.busy), 64'(0));

    // Simultaneous flush and start in IDLE.
    @(negedge clk);
    bus.A = 32'd7; bus.B = 32'd7; bus.flush = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    check("flush_start busy", 64'(bus.busy), 64'(0));
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("flush_start busy later", 64'(bus.busy), 64'(0));

    // Asynchronous reset in the middle of CALC.
    issue(32'd100, 32'd200, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst busy", 64'(bus.busy), 64'(0));
    check("async_rst done", 64'(bus.done), 64'(0));
    check("async_rst C", bus.C, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_and_check("post_rst", 32'd4, 32'd4, 1'b0, 64'd16);

    // Random regression against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'h0;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'h80000000;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'h1;
        default: rb = $urandom;
      endcase
      rs = 1'($urandom_range(0, 1));
      run_and_check($sformatf("rand%0d a=%h b=%h s=%0d", i, ra, rb, rs), ra, rb, rs, ref_mul(ra, rb, rs));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
